serial_add_driver: RTL and testbench

Transmit and collect end of the team's bit-serial adder link.
- Accepts two parallel WIDTH-bit operands.
- Shifts them out LSB-first as two serial bit streams (ser_a, ser_b) to the bit-serial adder.
- Captures the returned registered serial sum stream (ser_sum_in) into a parallel WIDTH+1-bit result, carry-out included.
- Sits between a parallel datapath and the serial adder. The adder has no reset, so this block clears the adder's carry register itself.

---
 rtl/serial_add_driver.sv | 120 ++++++++++++
 tb/tb_serial_add_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_driver.sv
// Parallel-to-serial operand driver and serial-to-parallel sum collector for the bit-serial adder.
// Optional SERIAL_SUB_EN adds a 'sub' input for A-B via carry preset and inverted B.
module serial_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             ser_a,
    output logic             ser_b,
    input  logic             ser_sum_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, DRAIN, DONE} state_t;

    state_t         state, next;
    logic [CW-1:0]  cnt;
    logic [WIDTH:0] a_sh, b_sh, cap, res_q, b_load;
    logic           cap_en, load, flush_bit;

`ifdef SERIAL_SUB_EN
    logic sub_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            sub_q <= 1'b0;
        else if (load)
            sub_q <= sub;
    end

    // Pad bit stays 0 so result[WIDTH] reads as the no-borrow flag.
    assign flush_bit = sub_q;
    assign b_load    = sub ? {1'b0, ~b_in} : {1'b0, b_in};
`else
    assign flush_bit = 1'b0;
    assign b_load    = {1'b0, b_in};
`endif

    always_comb begin
        next  = state;
        load  = 1'b0;
        ser_a = 1'b0;
        ser_b = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    next = FLUSH;
                end
            end
            FLUSH: begin
                // Drives the adder's carry register to a known value.
                ser_a = flush_bit;
                ser_b = flush_bit;
                next  = SHIFT;
            end
            SHIFT: begin
                ser_a = a_sh[0];
                ser_b = b_sh[0];
                if (cnt == LAST)
                    next = DRAIN;
            end
            DRAIN: next = DONE;
            DONE: begin
                if (start) begin
                    load = 1'b1;
                    next = FLUSH;
                end else begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cap    <= '0;
            cap_en <= 1'b0;
            res_q  <= '0;
        end else begin
            state  <= next;
            cap_en <= (state == SHIFT);
            if (load) begin
                a_sh <= {1'b0, a_in};
                b_sh <= b_load;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt + CW'(1);
            end
            if (cap_en)
                cap <= {ser_sum_in, cap[WIDTH:1]};
            // Last sample arrives on the DRAIN edge, so publish it alongside the shifted register.
            if (state == DRAIN)
                res_q <= {ser_sum_in, cap[WIDTH:1]};
        end
    end

    assign busy   = (state == FLUSH) || (state == SHIFT) || (state == DRAIN);
    assign done   = (state == DONE);
    assign result = res_q;

endmodule

// File: tb/tb_serial_add_driver.sv
// Bench for serial_add_driver: a registered full-adder model closes the serial loop,
// expected sums come from plain arithmetic.
module tb_serial_add_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, ser_a, ser_b, ser_sum_in, busy, done;
    logic [W-1:0] a_in, b_in;
    logic [W:0]   result;
`ifdef SERIAL_SUB_EN
    logic         sub;
`endif

    int errors = 0;
    int checks = 0;
    int unsigned last_exp = 0;

    always #5 clk = ~clk;

    // Bit-serial adder with registered sum and carry, no reset.
    logic add_s, add_c;
    always @(posedge clk) begin
        add_s <= ser_a ^ ser_b ^ add_c;
        add_c <= (ser_a & ser_b) | (ser_a & add_c) | (ser_b & add_c);
    end
    assign ser_sum_in = add_s;

    serial_add_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
`ifdef SERIAL_SUB_EN
        .sub        (sub),
`endif
        .ser_a      (ser_a),
        .ser_b      (ser_b),
        .ser_sum_in (ser_sum_in),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    vec_t tbl[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned ref_result(input int unsigned a, input int unsigned b,
                                               input bit s);
        if (s)
            return (a + (1 << W) - b) % (1 << (W + 1));
        return (a + b) % (1 << (W + 1));
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input int unsigned exp, input string name);
        int n;
        int bcnt;
        a_in  = a;
        b_in  = b;
`ifdef SERIAL_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        n    = 0;
        bcnt = 0;
        while (!done && n < 100) begin
            if (busy) bcnt++;
            if (n == 5) chk({name, " held"}, result, last_exp);
            tick();
            n++;
        end
        chk({name, " latency"}, n, W + 3);
        chk({name, " busy"}, bcnt, W + 3);
        chk({name, " result"}, result, exp);
        last_exp = exp;
        tick();
        chk({name, " pulse"}, done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ndone;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
`ifdef SERIAL_SUB_EN
        sub   = 1'b0;
`endif
        tbl[0] = '{8'h03, 8'h05, 9'h008};
        tbl[1] = '{8'hFF, 8'h01, 9'h100};
        tbl[2] = '{8'hFF, 8'hFF, 9'h1FE};
        tbl[3] = '{8'h00, 8'h00, 9'h000};
        tbl[4] = '{8'h12, 8'h34, 9'h046};
        for (int i = 5; i < 12; i++) begin
            tbl[i].a   = W'($urandom);
            tbl[i].b   = W'($urandom);
            tbl[i].exp = (W + 1)'(ref_result(tbl[i].a, tbl[i].b, 1'b0));
        end

        // Reset state
        tick(); tick(); tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst result", result, 0);
        chk("rst ser_a", ser_a, 0);
        chk("rst ser_b", ser_b, 0);
        rst_n = 1'b1;
        tick();

        // Vector table; the first op runs with the adder carry never initialised
        for (int i = 0; i < 12; i++)
            run_op(tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp, $sformatf("vec%0d", i));

        // Back-to-back with start held
        a_in  = 8'hFF;
        b_in  = 8'h01;
        start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("b2b first result", result, 9'h100);
        a_in = 8'hFF;
        b_in = 8'hFF;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("b2b spacing", n, W + 4);
        chk("b2b second result", result, 9'h1FE);
        tick();
        chk("b2b pulse", done, 0);
        last_exp = 9'h1FE;

        // Start pulse during SHIFT is ignored
        a_in  = 8'h12;
        b_in  = 8'h34;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 4) begin
                a_in  = 8'hAA;
                b_in  = 8'h55;
                start = 1'b1;
            end
            if (i == 5) start = 1'b0;
            tick();
            if (done) begin
                ndone++;
                chk("ignore result", result, 9'h046);
            end
        end
        chk("ignore done count", ndone, 1);
        chk("ignore final result", result, 9'h046);
        last_exp = 9'h046;

        // Reset at SHIFT cnt=4
        a_in  = 8'h77;
        b_in  = 8'h66;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst result", result, 0);
        chk("midrst ser_a", ser_a, 0);
        chk("midrst ser_b", ser_b, 0);
        last_exp = 0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("midrst no done", ndone, 0);
        run_op(8'h12, 8'h34, 1'b0, 9'h046, "after rst");

`ifdef SERIAL_SUB_EN
        run_op(8'h05, 8'h03, 1'b1, 9'h102, "sub 5-3");
        run_op(8'h03, 8'h05, 1'b1, 9'h0FE, "sub 3-5");
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] ra, rb;
            bit rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, ref_result(ra, rb, rs), $sformatf("rsub%0d", i));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
